// File: rtl/evt_delay_scheduler_if.sv
// evt_delay_scheduler_if: request/event bundle between a requester and the delay scheduler.
interface evt_delay_scheduler_if #(
    parameter int DELAY_W = 8,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16
);
    logic [DELAY_W-1:0] delay_cfg;
    logic               req_delayed;
    logic               req_direct;
    logic               evt_out;
    logic [TS_W-1:0]    evt_time;
    logic               coincide;
    logic               busy;
    logic [DELAY_W-1:0] remaining;
    logic [CNT_W-1:0]   dropped_cnt;
    logic [TS_W-1:0]    ts;

    modport master (
        output delay_cfg, req_delayed, req_direct,
        input  evt_out, evt_time, coincide, busy, remaining, dropped_cnt, ts
    );
    modport slave (
        input  delay_cfg, req_delayed, req_direct,
        output evt_out, evt_time, coincide, busy, remaining, dropped_cnt, ts
    );
endinterface

// File: rtl/evt_delay_scheduler.sv
// evt_delay_scheduler: merges delayed and direct event requests into one timestamped pulse stream.
module evt_delay_scheduler #(
    parameter int DELAY_W = 8,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst_n,
    evt_delay_scheduler_if.slave bus
);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t             state, state_nx;
    logic [DELAY_W-1:0] remaining, remaining_nx, d_eff;
    logic [TS_W-1:0]    ts, evt_time;
    logic [CNT_W-1:0]   dropped_cnt;
    logic               evt_out, coincide, drop, dly_fire_nx, fire_nx;

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        drop         = 1'b0;
        dly_fire_nx  = 1'b0;
        d_eff        = (bus.delay_cfg == '0) ? DELAY_W'(1) : bus.delay_cfg;
        if (state == IDLE) begin
            state_nx     = bus.req_delayed ? ARMED : IDLE;
            remaining_nx = bus.req_delayed ? d_eff : '0;
            dly_fire_nx  = bus.req_delayed && d_eff == DELAY_W'(1);
        end else begin
            drop         = bus.req_delayed;
            remaining_nx = remaining - 1'b1;
            // pulse is registered, so it is launched one count before expiry
            dly_fire_nx  = remaining == DELAY_W'(2);
            state_nx     = (remaining == DELAY_W'(1)) ? IDLE : ARMED;
        end
    end

    assign fire_nx = dly_fire_nx || bus.req_direct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            ts          <= '0;
            evt_time    <= '0;
            evt_out     <= 1'b0;
            coincide    <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            state       <= state_nx;
            remaining   <= remaining_nx;
            ts          <= ts + 1'b1;
            evt_out     <= fire_nx;
            coincide    <= dly_fire_nx && bus.req_direct;
            evt_time    <= fire_nx ? ts + 1'b1 : evt_time;
            dropped_cnt <= (drop && dropped_cnt != '1) ? dropped_cnt + 1'b1 : dropped_cnt;
        end
    end

    assign bus.busy        = state == ARMED;
    assign bus.remaining   = remaining;
    assign bus.ts          = ts;
    assign bus.evt_time    = evt_time;
    assign bus.evt_out     = evt_out;
    assign bus.coincide    = coincide;
    assign bus.dropped_cnt = dropped_cnt;
endmodule

// File: tb/tb_evt_delay_scheduler.sv
// tb_evt_delay_scheduler: table-driven directed checks of the delay scheduler, plus a mid-delay reset sequence.
module tb_evt_delay_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    evt_delay_scheduler_if bus ();
    evt_delay_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          ph;
        int          cyc;
        logic        rd;
        logic        rq;
        logic [7:0]  d;
        logic        chk;
        logic        evt;
        logic        coin;
        logic        busy;
        logic [7:0]  rem;
        logic [31:0] et;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[$];
    int   evts0[$] = '{110, 210, 306, 310, 410, 451, 452};
    int   evts1[$] = '{71};

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h want %0h", name, c, act, exp);
    endtask

    function automatic logic is_evt(input int ph, input int c);
        int q[$];
        q = (ph == 0) ? evts0 : evts1;
        foreach (q[i]) if (q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // one iteration per cycle: drive inputs, check at negedge, move into the next cycle
    task automatic run(input int ph, input int last);
        for (int c = 0; c <= last; c++) begin
            bus.req_delayed = 1'b0;
            bus.req_direct  = 1'b0;
            bus.delay_cfg   = 8'd0;
            foreach (vecs[i]) if (vecs[i].ph == ph && vecs[i].cyc == c) begin
                bus.req_delayed = vecs[i].rd;
                bus.req_direct  = vecs[i].rq;
                bus.delay_cfg   = vecs[i].d;
            end
            @(negedge clk);
            chk("evt_out", c, 32'(bus.evt_out), 32'(is_evt(ph, c)));
            foreach (vecs[i]) if (vecs[i].ph == ph && vecs[i].cyc == c && vecs[i].chk) begin
                chk("ts", c, bus.ts, 32'(c));
                chk("coincide", c, 32'(bus.coincide), 32'(vecs[i].coin));
                chk("busy", c, 32'(bus.busy), 32'(vecs[i].busy));
                chk("remaining", c, 32'(bus.remaining), 32'(vecs[i].rem));
                chk("evt_time", c, bus.evt_time, vecs[i].et);
                chk("dropped_cnt", c, 32'(bus.dropped_cnt), 32'(vecs[i].drop));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs.push_back('{0,   0, 0, 0,  0, 1, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0,  99, 0, 0,  0, 1, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 100, 1, 0, 10, 1, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 101, 0, 0,  0, 1, 0, 0, 1, 10,   0, 0});
        vecs.push_back('{0, 105, 0, 0,  0, 1, 0, 0, 1,  6,   0, 0});
        vecs.push_back('{0, 109, 0, 0,  0, 1, 0, 0, 1,  2,   0, 0});
        vecs.push_back('{0, 110, 0, 0,  0, 1, 1, 0, 1,  1, 110, 0});
        vecs.push_back('{0, 111, 0, 0,  0, 1, 0, 0, 0,  0, 110, 0});
        vecs.push_back('{0, 200, 1, 0, 10, 1, 0, 0, 0,  0, 110, 0});
        vecs.push_back('{0, 205, 1, 0,  3, 1, 0, 0, 1,  6, 110, 0});
        vecs.push_back('{0, 206, 0, 0,  0, 1, 0, 0, 1,  5, 110, 1});
        vecs.push_back('{0, 210, 1, 0, 10, 1, 1, 0, 1,  1, 210, 1});
        vecs.push_back('{0, 211, 0, 0,  0, 1, 0, 0, 0,  0, 210, 2});
        vecs.push_back('{0, 220, 0, 0,  0, 1, 0, 0, 0,  0, 210, 2});
        vecs.push_back('{0, 300, 1, 0, 10, 0, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 305, 0, 1,  0, 1, 0, 0, 1,  6, 210, 2});
        vecs.push_back('{0, 306, 0, 0,  0, 1, 1, 0, 1,  5, 306, 2});
        vecs.push_back('{0, 310, 0, 0,  0, 1, 1, 0, 1,  1, 310, 2});
        vecs.push_back('{0, 400, 1, 0, 10, 0, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 409, 0, 1,  0, 1, 0, 0, 1,  2, 310, 2});
        vecs.push_back('{0, 410, 0, 0,  0, 1, 1, 1, 1,  1, 410, 2});
        vecs.push_back('{0, 411, 0, 0,  0, 1, 0, 0, 0,  0, 410, 2});
        vecs.push_back('{0, 450, 0, 1,  0, 0, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 451, 0, 1,  0, 1, 1, 0, 0,  0, 451, 2});
        vecs.push_back('{0, 452, 0, 0,  0, 1, 1, 0, 0,  0, 452, 2});
        vecs.push_back('{0, 500, 1, 0, 50, 0, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{0, 504, 0, 0,  0, 1, 0, 0, 1, 47, 452, 2});
        vecs.push_back('{1,   0, 0, 0,  0, 1, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{1,  70, 1, 0,  0, 1, 0, 0, 0,  0,   0, 0});
        vecs.push_back('{1,  71, 0, 0,  0, 1, 1, 0, 1,  1,  71, 0});
        vecs.push_back('{1,  72, 0, 0,  0, 1, 0, 0, 0,  0,  71, 0});

        bus.req_delayed = 1'b0;
        bus.req_direct  = 1'b0;
        bus.delay_cfg   = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(0, 504);
        // now in cycle 505 with a 50-cycle delay pending: reset must clear everything at once
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 505, 32'(bus.busy), 32'd0);
        chk("rst_remaining", 505, 32'(bus.remaining), 32'd0);
        chk("rst_dropped", 505, 32'(bus.dropped_cnt), 32'd0);
        chk("rst_ts", 505, bus.ts, 32'd0);
        chk("rst_evt_time", 505, bus.evt_time, 32'd0);
        chk("rst_evt_out", 505, 32'(bus.evt_out), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(1, 80);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
